// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM state and BTB counter helpers.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FETCH      = 2'd0,
      REDIR_PEND = 2'd1,
      HALTED     = 2'd2
   } fetch_state_t;

   typedef logic [1:0] btb_ctr_t;

   localparam btb_ctr_t BTB_CTR_INIT = 2'b01;
   localparam word_t    PC_STEP      = 32'd4;

   function automatic btb_ctr_t ctr_inc(input btb_ctr_t c);
      return (c == 2'b11) ? 2'b11 : c + 2'b01;
   endfunction

   function automatic btb_ctr_t ctr_dec(input btb_ctr_t c);
      return (c == 2'b00) ? 2'b00 : c - 2'b01;
   endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
module fetch_btb
   import cpu_types_pkg::*;
#(
   parameter int ENTRIES = 16
) (
   input  logic  CLK,
   input  logic  nRST,
   input  word_t lookup_pc,
   output logic  hit,
   output word_t target,
   input  logic  upd_valid,
   input  word_t upd_pc,
   input  word_t upd_target,
   input  logic  upd_taken
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 32 - IDX_W - 2;

   logic               valid_r  [ENTRIES];
   logic [TAG_W-1:0]   tag_r    [ENTRIES];
   word_t              target_r [ENTRIES];
   btb_ctr_t           ctr_r    [ENTRIES];

   logic [IDX_W-1:0]   look_idx_s;
   logic [TAG_W-1:0]   look_tag_s;
   logic [IDX_W-1:0]   upd_idx_s;
   logic [TAG_W-1:0]   upd_tag_s;
   logic               upd_hit_s;
   logic               unused_s;

   assign look_idx_s = lookup_pc[IDX_W+1:2];
   assign look_tag_s = lookup_pc[31:IDX_W+2];
   assign upd_idx_s  = upd_pc[IDX_W+1:2];
   assign upd_tag_s  = upd_pc[31:IDX_W+2];
   assign upd_hit_s  = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
   assign unused_s   = ^{lookup_pc[1:0], upd_pc[1:0]};

   // Lookup reads registered entries, so a same-cycle update is not visible yet.
   always_comb begin
      hit    = 1'b0;
      target = target_r[look_idx_s];
      if (valid_r[look_idx_s] && (tag_r[look_idx_s] == look_tag_s) && ctr_r[look_idx_s][1]) begin
         hit = 1'b1;
      end else begin
         hit = 1'b0;
      end
   end

   // Entry training from EX-stage resolution.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_r[i]  <= 1'b0;
            tag_r[i]    <= '0;
            target_r[i] <= 32'd0;
            ctr_r[i]    <= BTB_CTR_INIT;
         end
      end else if (upd_valid) begin
         if (upd_taken) begin
            valid_r[upd_idx_s]  <= 1'b1;
            tag_r[upd_idx_s]    <= upd_tag_s;
            target_r[upd_idx_s] <= upd_target;
            ctr_r[upd_idx_s]    <= upd_hit_s ? ctr_inc(ctr_r[upd_idx_s]) : ctr_inc(BTB_CTR_INIT);
         end else if (upd_hit_s) begin
            ctr_r[upd_idx_s]    <= ctr_dec(ctr_r[upd_idx_s]);
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC register, icache request, redirect/halt handling.
// Optional branch prediction is built when FETCH_BTB_EN is defined.
module fetch_unit
   import cpu_types_pkg::*;
#(
   parameter word_t RESET_PC    = 32'h0000_0000,
   parameter int    BTB_ENTRIES = 16
) (
   input  logic  CLK,
   input  logic  nRST,
   input  logic  ihit,
   input  logic  stall,
   input  logic  halt,
   input  logic  redirect_valid,
   input  word_t redirect_pc,
   input  logic  bpu_upd_valid,
   input  word_t bpu_upd_pc,
   input  word_t bpu_upd_target,
   input  logic  bpu_upd_taken,
   output logic  iREN,
   output word_t imemaddr,
   output word_t PC,
   output word_t npc,
   output logic  pred_taken,
   output logic  flushed
);

   fetch_state_t state_r;
   word_t        pc_r;
   word_t        pend_pc_r;
   logic         iren_r;

   word_t        redir_s;
   word_t        pc_plus4_s;
   word_t        pred_next_s;
   logic         pred_s;
   logic         unused_s;

   assign redir_s    = {redirect_pc[31:2], 2'b00};
   assign pc_plus4_s = pc_r + PC_STEP;

`ifdef FETCH_BTB_EN
   logic  btb_hit_s;
   word_t btb_target_s;

   fetch_btb #(
      .ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .CLK        (CLK),
      .nRST       (nRST),
      .lookup_pc  (pc_r),
      .hit        (btb_hit_s),
      .target     (btb_target_s),
      .upd_valid  (bpu_upd_valid),
      .upd_pc     (bpu_upd_pc),
      .upd_target (bpu_upd_target),
      .upd_taken  (bpu_upd_taken)
   );

   // Prediction only steers fetch while actively fetching.
   always_comb begin
      pred_s      = 1'b0;
      pred_next_s = pc_plus4_s;
      if (btb_hit_s && (state_r == FETCH)) begin
         pred_s      = 1'b1;
         pred_next_s = btb_target_s;
      end else begin
         pred_s      = 1'b0;
         pred_next_s = pc_plus4_s;
      end
   end

   assign unused_s = ^{redirect_pc[1:0]};
`else
   assign pred_s      = 1'b0;
   assign pred_next_s = pc_plus4_s;
   assign unused_s    = ^{bpu_upd_valid, bpu_upd_pc, bpu_upd_target, bpu_upd_taken,
                          redirect_pc[1:0], (BTB_ENTRIES > 0)};
`endif

   // Fetch FSM: halt > redirect > advance > hold.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_r   <= FETCH;
         pc_r      <= RESET_PC;
         pend_pc_r <= 32'd0;
         iren_r    <= 1'b1;
      end else begin
         case (state_r)
            FETCH: begin
               if (halt) begin
                  state_r <= HALTED;
                  iren_r  <= 1'b0;
               end else if (redirect_valid) begin
                  if (ihit) begin
                     pc_r <= redir_s;
                  end else begin
                     // The miss in flight keeps its address; restart after it lands.
                     pend_pc_r <= redir_s;
                     state_r   <= REDIR_PEND;
                  end
               end else if (ihit && !stall) begin
                  pc_r <= pred_next_s;
               end
            end
            REDIR_PEND: begin
               if (halt) begin
                  state_r <= HALTED;
                  iren_r  <= 1'b0;
               end else if (ihit) begin
                  pc_r    <= redirect_valid ? redir_s : pend_pc_r;
                  state_r <= FETCH;
               end else if (redirect_valid) begin
                  pend_pc_r <= redir_s;
               end
            end
            HALTED: begin
               iren_r <= 1'b0;
            end
            default: begin
               state_r <= FETCH;
               iren_r  <= 1'b1;
            end
         endcase
      end
   end

   // Wrong-path marker for the instruction returning this cycle.
   always_comb begin
      flushed = 1'b0;
      case (state_r)
         FETCH:      flushed = redirect_valid;
         REDIR_PEND: flushed = 1'b1;
         HALTED:     flushed = 1'b0;
         default:    flushed = 1'b0;
      endcase
   end

   assign iREN       = iren_r;
   assign imemaddr   = pc_r;
   assign PC         = pc_r;
   assign npc        = pc_plus4_s;
   assign pred_taken = pred_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (optionally with FETCH_BTB_EN).
module tb_fetch_unit;
   import cpu_types_pkg::*;

   logic  CLK = 1'b0;
   logic  nRST;
   logic  ihit, stall, halt, redirect_valid;
   word_t redirect_pc;
   logic  bpu_upd_valid, bpu_upd_taken;
   word_t bpu_upd_pc, bpu_upd_target;
   logic  iREN, pred_taken, flushed;
   word_t imemaddr, PC, npc;

   int vec_cnt = 0;
   int err_cnt = 0;

   fetch_unit #(.RESET_PC(32'h0000_0000), .BTB_ENTRIES(16)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .stall(stall), .halt(halt),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .bpu_upd_valid(bpu_upd_valid), .bpu_upd_pc(bpu_upd_pc),
      .bpu_upd_target(bpu_upd_target), .bpu_upd_taken(bpu_upd_taken),
      .iREN(iREN), .imemaddr(imemaddr), .PC(PC), .npc(npc),
      .pred_taken(pred_taken), .flushed(flushed)
   );

   always #5 CLK = ~CLK;

   task automatic cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      nRST = 1'b0; ihit = 1'b0; stall = 1'b0; halt = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'd0;
      bpu_upd_valid = 1'b0; bpu_upd_pc = 32'd0; bpu_upd_target = 32'd0; bpu_upd_taken = 1'b0;
      repeat (2) @(posedge CLK);
      #1 nRST = 1'b1;
   endtask

   task automatic goto_pc(input word_t a);
      redirect_valid = 1'b1; redirect_pc = a; ihit = 1'b1; stall = 1'b0; halt = 1'b0;
      cycle();
      redirect_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vec_cnt++;
      if (iREN !== 1'b1 || pred_taken !== 1'b0 || PC !== 32'h0) begin
         err_cnt++; $display("FAIL reset_state: got iREN=%b pred=%b PC=%h expected 1 0 00000000", iREN, pred_taken, PC);
      end
      ihit = 1'b1; stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         vec_cnt++;
         if (imemaddr !== 32'(4 * i) || npc !== 32'(4 * i + 4) || flushed !== 1'b0) begin
            err_cnt++; $display("FAIL seq_fetch[%0d]: got addr=%h npc=%h fl=%b expected %h %h 0",
                                i, imemaddr, npc, flushed, 32'(4 * i), 32'(4 * i + 4));
         end
         cycle();
      end
   endtask

   task automatic test_redirect_hit();
      goto_pc(32'h40);
      redirect_valid = 1'b1; redirect_pc = 32'h103; ihit = 1'b1;
      #1;
      vec_cnt++;
      if (flushed !== 1'b1 || imemaddr !== 32'h40) begin
         err_cnt++; $display("FAIL redir_hit_flush: got fl=%b addr=%h expected 1 00000040", flushed, imemaddr);
      end
      cycle();
      redirect_valid = 1'b0;
      #1;
      vec_cnt++;
      if (imemaddr !== 32'h100 || flushed !== 1'b0) begin
         err_cnt++; $display("FAIL redir_hit_addr: got addr=%h fl=%b expected 00000100 0", imemaddr, flushed);
      end
   endtask

   task automatic test_redirect_miss();
      goto_pc(32'h80);
      ihit = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
      #1;
      vec_cnt++;
      if (flushed !== 1'b1 || imemaddr !== 32'h80) begin
         err_cnt++; $display("FAIL miss_redir1: got fl=%b addr=%h expected 1 00000080", flushed, imemaddr);
      end
      cycle();
      redirect_valid = 1'b0;
      #1;
      vec_cnt++;
      if (flushed !== 1'b1 || imemaddr !== 32'h80) begin
         err_cnt++; $display("FAIL miss_pend: got fl=%b addr=%h expected 1 00000080", flushed, imemaddr);
      end
      cycle();
      redirect_valid = 1'b1; redirect_pc = 32'h300;
      cycle();
      redirect_valid = 1'b0; ihit = 1'b1; stall = 1'b1;
      #1;
      vec_cnt++;
      if (flushed !== 1'b1 || imemaddr !== 32'h80) begin
         err_cnt++; $display("FAIL miss_land: got fl=%b addr=%h expected 1 00000080", flushed, imemaddr);
      end
      cycle();
      stall = 1'b0;
      vec_cnt++;
      if (imemaddr !== 32'h300 || flushed !== 1'b0) begin
         err_cnt++; $display("FAIL miss_restart: got addr=%h fl=%b expected 00000300 0", imemaddr, flushed);
      end
      // Redirect arriving on the landing cycle wins over the pending one.
      ihit = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h600;
      cycle();
      ihit = 1'b1; redirect_pc = 32'h704;
      cycle();
      redirect_valid = 1'b0;
      vec_cnt++;
      if (imemaddr !== 32'h704) begin
         err_cnt++; $display("FAIL miss_late_redir: got addr=%h expected 00000704", imemaddr);
      end
   endtask

   task automatic test_stall();
      goto_pc(32'h20);
      ihit = 1'b1; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         vec_cnt++;
         if (imemaddr !== 32'h20 || npc !== 32'h24) begin
            err_cnt++; $display("FAIL stall_hold[%0d]: got addr=%h npc=%h expected 00000020 00000024", i, imemaddr, npc);
         end
      end
      stall = 1'b0;
      cycle();
      vec_cnt++;
      if (imemaddr !== 32'h24) begin
         err_cnt++; $display("FAIL stall_release: got addr=%h expected 00000024", imemaddr);
      end
      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h60;
      cycle();
      redirect_valid = 1'b0; stall = 1'b0;
      vec_cnt++;
      if (imemaddr !== 32'h60) begin
         err_cnt++; $display("FAIL stall_redirect: got addr=%h expected 00000060", imemaddr);
      end
   endtask

   task automatic test_wrap();
      goto_pc(32'hFFFF_FFFC);
      ihit = 1'b1; stall = 1'b0;
      vec_cnt++;
      if (npc !== 32'h0) begin
         err_cnt++; $display("FAIL wrap_npc: got npc=%h expected 00000000", npc);
      end
      cycle();
      vec_cnt++;
      if (imemaddr !== 32'h0) begin
         err_cnt++; $display("FAIL wrap_addr: got addr=%h expected 00000000", imemaddr);
      end
   endtask

   task automatic test_btb();
      do_reset();
      goto_pc(32'h10);
      vec_cnt++;
      if (pred_taken !== 1'b0 || npc !== 32'h14) begin
         err_cnt++; $display("FAIL btb_cold: got pred=%b npc=%h expected 0 00000014", pred_taken, npc);
      end
      ihit = 1'b0;
      bpu_upd_valid = 1'b1; bpu_upd_pc = 32'h10; bpu_upd_target = 32'h50; bpu_upd_taken = 1'b1;
      cycle();
      cycle();
      bpu_upd_valid = 1'b0;
`ifdef FETCH_BTB_EN
      vec_cnt++;
      if (pred_taken !== 1'b1) begin
         err_cnt++; $display("FAIL btb_trained: got pred=%b expected 1", pred_taken);
      end
      ihit = 1'b1;
      cycle();
      vec_cnt++;
      if (imemaddr !== 32'h50) begin
         err_cnt++; $display("FAIL btb_target: got addr=%h expected 00000050", imemaddr);
      end
      bpu_upd_valid = 1'b1; bpu_upd_taken = 1'b0; ihit = 1'b0;
      cycle();
      bpu_upd_valid = 1'b0;
      goto_pc(32'h10);
      vec_cnt++;
      if (pred_taken !== 1'b1 || npc !== 32'h14) begin
         err_cnt++; $display("FAIL btb_weak_taken: got pred=%b npc=%h expected 1 00000014", pred_taken, npc);
      end
      cycle();
      vec_cnt++;
      if (imemaddr !== 32'h50) begin
         err_cnt++; $display("FAIL btb_weak_target: got addr=%h expected 00000050", imemaddr);
      end
`else
      vec_cnt++;
      if (pred_taken !== 1'b0) begin
         err_cnt++; $display("FAIL nobtb_pred: got pred=%b expected 0", pred_taken);
      end
      ihit = 1'b1;
      cycle();
      vec_cnt++;
      if (imemaddr !== 32'h14) begin
         err_cnt++; $display("FAIL nobtb_seq: got addr=%h expected 00000014", imemaddr);
      end
`endif
   endtask

   task automatic test_reset_mid_miss();
      goto_pc(32'h80);
      ihit = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
      cycle();
      redirect_valid = 1'b0;
      do_reset();
      ihit = 1'b1;
      #1;
      vec_cnt++;
      if (flushed !== 1'b0 || imemaddr !== 32'h0) begin
         err_cnt++; $display("FAIL midmiss_reset: got fl=%b addr=%h expected 0 00000000", flushed, imemaddr);
      end
      cycle();
      vec_cnt++;
      if (imemaddr !== 32'h4) begin
         err_cnt++; $display("FAIL midmiss_resume: got addr=%h expected 00000004", imemaddr);
      end
   endtask

   task automatic test_halt();
      goto_pc(32'h44);
      halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500; ihit = 1'b1;
      cycle();
      halt = 1'b0;
      vec_cnt++;
      if (iREN !== 1'b0 || imemaddr !== 32'h44 || flushed !== 1'b0) begin
         err_cnt++; $display("FAIL halt_enter: got iREN=%b addr=%h fl=%b expected 0 00000044 0", iREN, imemaddr, flushed);
      end
      cycle();
      redirect_valid = 1'b0;
      vec_cnt++;
      if (imemaddr !== 32'h44 || iREN !== 1'b0) begin
         err_cnt++; $display("FAIL halt_frozen: got addr=%h iREN=%b expected 00000044 0", imemaddr, iREN);
      end
      nRST = 1'b0;
      #1;
      vec_cnt++;
      if (imemaddr !== 32'h0 || iREN !== 1'b1) begin
         err_cnt++; $display("FAIL halt_reset: got addr=%h iREN=%b expected 00000000 1", imemaddr, iREN);
      end
      @(posedge CLK);
      #1 nRST = 1'b1;
   endtask

   initial begin
      test_reset();
      test_redirect_hit();
      test_redirect_miss();
      test_stall();
      test_wrap();
      test_btb();
      test_reset_mid_miss();
      test_halt();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
